// File: rtl/instr_boot_ctrl.sv
// rtl/instr_boot_ctrl.sv - boot sequencer: load settle filter, optional ROM checksum scan, CPU release/halt
// Optional checksum scan is built when INSTR_BOOT_CHECKSUM_EN is defined; otherwise IDLE goes straight to READY.
module instr_boot_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DONE_STABLE = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_transmit_done,
    input  logic [ADDR_W-1:0] i_max_addr,
    input  logic              i_start,
    input  logic              i_cpu_halt,
    input  logic [ADDR_W-1:0] i_cpu_pc,
    input  logic [DATA_W-1:0] i_instr_read,
    output logic [ADDR_W-1:0] o_addr_read,
    output logic              o_cpu_rst_n,
    output logic              o_cpu_en,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_checksum,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VERIFY = 3'd1,
        S_READY  = 3'd2,
        S_RUN    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam int              CNT_W   = $clog2(DONE_STABLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DONE_STABLE);

`ifdef INSTR_BOOT_CHECKSUM_EN
    localparam state_t LOAD_NEXT = S_VERIFY;
`else
    localparam state_t LOAD_NEXT = S_READY;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cpu_rst_n_q;
    logic              cpu_en_q;
    logic              ready_q;
    logic              scan_done;
    logic [ADDR_W-1:0] scan_addr;

    // Done filter: consecutive-high count, saturating
    always_comb begin
        cnt_d = '0;
        if (i_transmit_done) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Reload (done dropping outside IDLE) overrides every other transition
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && !i_transmit_done) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (cnt_q == CNT_MAX) state_d = LOAD_NEXT;
                S_VERIFY: if (scan_done)        state_d = S_READY;
                S_READY:  if (i_start)          state_d = S_RUN;
                S_RUN:    if (i_cpu_halt)       state_d = S_HALT;
                S_HALT:   if (i_start)          state_d = S_READY;
                default:                        state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cpu_rst_n_q <= 1'b0;
            cpu_en_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_rst_n_q <= (state_d == S_RUN) || (state_d == S_HALT);
            cpu_en_q    <= (state_d == S_RUN);
            ready_q     <= (state_d == S_READY);
        end
    end

`ifdef INSTR_BOOT_CHECKSUM_EN
    logic [ADDR_W-1:0] max_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sum_q;
    logic              vld_q;
    logic              last_q;
    logic              issued_q;

    assign scan_done  = vld_q && last_q;
    assign scan_addr  = addr_q;
    assign o_checksum = sum_q;

    // Address held at max_q once issued so the scan never wraps; vld/last trail the ROM's 1-cycle latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            max_q    <= '0;
            addr_q   <= '0;
            sum_q    <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            issued_q <= 1'b0;
        end else if (state_d == S_IDLE) begin
            addr_q   <= '0;
            sum_q    <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            issued_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            max_q    <= i_max_addr;
            addr_q   <= '0;
            sum_q    <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            issued_q <= 1'b0;
        end else if (state_q == S_VERIFY) begin
            vld_q <= !issued_q;
            if (!issued_q) begin
                last_q <= (addr_q == max_q);
                if (addr_q == max_q) begin
                    issued_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end
            if (vld_q) begin
                sum_q <= sum_q + i_instr_read;
            end
        end
    end
`else
    logic unused_scan_inputs;

    assign unused_scan_inputs = ^{i_max_addr, i_instr_read};
    assign scan_done          = 1'b0;
    assign scan_addr          = '0;
    assign o_checksum         = '0;
`endif

    always_comb begin
        o_addr_read = '0;
        case (state_q)
            S_VERIFY:      o_addr_read = scan_addr;
            S_RUN, S_HALT: o_addr_read = i_cpu_pc;
            default:       o_addr_read = '0;
        endcase
    end

    assign o_cpu_rst_n = cpu_rst_n_q;
    assign o_cpu_en    = cpu_en_q;
    assign o_ready     = ready_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_instr_boot_ctrl.sv
// tb/tb_instr_boot_ctrl.sv - self-checking bench for instr_boot_ctrl (checksum paths under INSTR_BOOT_CHECKSUM_EN)
module tb_instr_boot_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DS     = 4;
`ifdef INSTR_BOOT_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              done = 1'b0;
    logic [ADDR_W-1:0] max_addr = '0;
    logic              start = 1'b0;
    logic              halt = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic [DATA_W-1:0] instr = '0;
    logic [ADDR_W-1:0] addr_read;
    logic              cpu_rst_n;
    logic              cpu_en;
    logic              ready;
    logic [DATA_W-1:0] checksum;
    logic [2:0]        state;

    logic [DATA_W-1:0] rom [256];

    instr_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DONE_STABLE(DS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_transmit_done(done), .i_max_addr(max_addr),
        .i_start(start), .i_cpu_halt(halt), .i_cpu_pc(pc), .i_instr_read(instr),
        .o_addr_read(addr_read), .o_cpu_rst_n(cpu_rst_n), .o_cpu_en(cpu_en),
        .o_ready(ready), .o_checksum(checksum), .o_state(state)
    );

    always #10 clk = ~clk;
    always @(posedge clk) instr <= rom[addr_read];

    typedef struct {
        logic [ADDR_W-1:0] max;
        logic [DATA_W-1:0] w0, w1, w2;
        logic [DATA_W-1:0] sum;
        bit                rnd;
    } scen_t;

    typedef struct {
        logic [DATA_W-1:0] sum;
        int                cyc;
        int                vcyc;
    } exp_t;

    scen_t tab [4];
    exp_t  sb [$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_to_ready(output int n, output int v);
        n = 0;
        v = 0;
        while (!ready && n < 600) begin
            @(negedge clk);
            n++;
            if (state == 3'd1) v++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n, v, k;

        tab[0] = '{max: 8'd2, w0: 16'h1111, w1: 16'h2222, w2: 16'h3333, sum: 16'h6666, rnd: 1'b0};
        tab[1] = '{max: 8'd1, w0: 16'hFFFF, w1: 16'h0002, w2: 16'h5555, sum: 16'h0001, rnd: 1'b0};
        tab[2] = '{max: 8'd0, w0: 16'hABCD, w1: 16'h1234, w2: 16'h4321, sum: 16'hABCD, rnd: 1'b0};
        tab[3] = '{max: 8'hFF, w0: 16'h0, w1: 16'h0, w2: 16'h0, sum: 16'h0, rnd: 1'b1};

        for (int a = 0; a < 256; a++) rom[a] = DATA_W'($urandom);
        pc = 8'h5A;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("reset_cpu_en", 32'(cpu_en), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_checksum", 32'(checksum), 32'd0);
        chk("reset_addr", 32'(addr_read), 32'd0);
        rst_n = 1'b1;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_idle_ignored", 32'(state), 32'd0);

        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < 256; a++) rom[a] = DATA_W'($urandom);
            if (!tab[s].rnd) begin
                rom[0] = tab[s].w0;
                rom[1] = tab[s].w1;
                rom[2] = tab[s].w2;
                e.sum = tab[s].sum;
            end else begin
                e.sum = '0;
                for (int a = 0; a <= int'(tab[s].max); a++) e.sum = e.sum + rom[a];
            end
            e.sum  = CK_EN ? e.sum : 16'h0;
            e.vcyc = CK_EN ? int'(tab[s].max) + 2 : 0;
            e.cyc  = DS + 1 + e.vcyc;
            sb.push_back(e);
            max_addr = tab[s].max;
            done = 1'b1;
            run_to_ready(n, v);
            e = sb.pop_front();
            chk($sformatf("scen%0d_cycles", s), 32'(n), 32'(e.cyc));
            chk($sformatf("scen%0d_verify_len", s), 32'(v), 32'(e.vcyc));
            chk($sformatf("scen%0d_checksum", s), 32'(checksum), 32'(e.sum));
            chk($sformatf("scen%0d_cpu_rst_n", s), 32'(cpu_rst_n), 32'd0);
            done = 1'b0;
            @(negedge clk);
            chk($sformatf("scen%0d_reload_state", s), 32'(state), 32'd0);
            chk($sformatf("scen%0d_reload_checksum", s), 32'(checksum), 32'd0);
            chk($sformatf("scen%0d_reload_ready", s), 32'(ready), 32'd0);
        end

        max_addr = 8'd2;
        done = 1'b1;
        repeat (3) @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        chk("glitch_still_idle", 32'(state), 32'd0);
        done = 1'b1;
        run_to_ready(n, v);
        chk("glitch_cycles", 32'(n), 32'(DS + 1 + (CK_EN ? 4 : 0)));

        chk("ready_addr", 32'(addr_read), 32'd0);
        chk("ready_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("halt_in_ready_ignored", 32'(state), 32'd2);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("run_cpu_en", 32'(cpu_en), 32'd1);
        chk("run_state", 32'(state), 32'd3);
        chk("run_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            logic [ADDR_W-1:0] pcs [5];
            pcs = '{8'h00, 8'h7F, 8'hFF, 8'h80, 8'h05};
            pc = pcs[i];
            #1;
            chk($sformatf("run_addr_pc%0d", i), 32'(addr_read), 32'(pcs[i]));
            @(negedge clk);
        end

        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("halt_cpu_en", 32'(cpu_en), 32'd0);
        chk("halt_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("halt_state", 32'(state), 32'd4);
        chk("halt_addr", 32'(addr_read), 32'h05);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("halt_start_state", 32'(state), 32'd2);
        chk("halt_start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("halt_start_ready", 32'(ready), 32'd1);
        chk("halt_start_addr", 32'(addr_read), 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        halt = 1'b0;
        chk("start_halt_same_cycle", 32'(state), 32'd4);

        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("rerun_state", 32'(state), 32'd3);
        done = 1'b0;
        @(negedge clk);
        chk("drop_run_state", 32'(state), 32'd0);
        chk("drop_run_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("drop_run_cpu_en", 32'(cpu_en), 32'd0);
        chk("drop_run_checksum", 32'(checksum), 32'd0);

`ifdef INSTR_BOOT_CHECKSUM_EN
        max_addr = 8'hFF;
        done = 1'b1;
        k = 0;
        while (state != 3'd1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("mid_verify_reached", 32'(state), 32'd1);
        repeat (3) @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        chk("drop_verify_state", 32'(state), 32'd0);
        chk("drop_verify_checksum", 32'(checksum), 32'd0);
`endif

        max_addr = 8'd0;
        done = 1'b1;
        run_to_ready(n, v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pc = 8'h33;
        chk("pre_reset_state", 32'(state), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("async_cpu_en", 32'(cpu_en), 32'd0);
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_checksum", 32'(checksum), 32'd0);
        chk("async_addr", 32'(addr_read), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
